// File: rtl/mmm_serial_core.sv
// Bit-serial Montgomery multiplier: p = a*b*2^-WIDTH mod m, one multiplier bit per enabled clock.
// Define MMM_FINAL_SUB_EN to add the CORR state (final conditional subtraction, p < m).
module mmm_serial_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   p
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LAST_I = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
`ifdef MMM_FINAL_SUB_EN
        CORR = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, m_reg;
    logic [WIDTH+1:0] r_reg, r_next;
    logic [CW-1:0]    i_reg;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] pp;
    logic             a_bit;
    logic [WIDTH+1:0] t_add, t_odd;

    assign a_bit = a_reg[i_reg[IW-1:0]];

    // Partial product: multiplicand gated by the current multiplier bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
        assign pp[gi] = b_reg[gi] & a_bit;
    end

    always_comb begin
        t_add  = r_reg + {2'b00, pp};
        t_odd  = t_add[0] ? (t_add + {2'b00, m_reg}) : t_add;
        r_next = t_odd >> 1;
    end

`ifdef MMM_FINAL_SUB_EN
    logic [WIDTH:0] r_sub, p_corr;

    // R < 2m < 2^(W+1), so the top accumulator bit is always zero here
    always_comb begin
        r_sub  = r_reg[WIDTH:0] - {1'b0, m_reg};
        p_corr = (r_reg >= {2'b00, m_reg}) ? r_sub : r_reg[WIDTH:0];
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else if (en) begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = ITER;
            ITER: begin
                if (i_reg == LAST_I) begin
`ifdef MMM_FINAL_SUB_EN
                    state_next = CORR;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef MMM_FINAL_SUB_EN
            CORR: state_next = DONE;
`endif
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            m_reg <= '0;
            r_reg <= '0;
            i_reg <= '0;
            p_reg <= '0;
        end else if (en) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        m_reg <= m;
                        r_reg <= '0;
                        i_reg <= '0;
                    end
                end
                ITER: begin
                    r_reg <= r_next;
                    i_reg <= i_reg + CW'(1);
`ifndef MMM_FINAL_SUB_EN
                    if (i_reg == LAST_I) p_reg <= r_next[WIDTH:0];
`endif
                end
`ifdef MMM_FINAL_SUB_EN
                CORR: p_reg <= p_corr;
`endif
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registers
    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
        p    = p_reg;
    end
endmodule

// File: tb/tb_mmm_serial_core.sv
// Scoreboard bench for mmm_serial_core: a tracker pushes reference results on accepted starts,
// a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_mmm_serial_core;
    localparam int W = 8;
`ifdef MMM_FINAL_SUB_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0, m = '0;
    logic         busy, done;
    logic [W:0]   p;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W:0] exp_q[$];
    int busy_left = 0;
    int cap_count = 0;
    bit checking = 0;
    bit en_toggle = 0;

    always #5 clk = ~clk;

    mmm_serial_core #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .a(a), .b(b), .m(m),
        .busy(busy), .done(done), .p(p)
    );

    // Montgomery product from its definition: q is the unique value mod 2^W
    // making a*b + q*m divisible by 2^W; the unreduced result lies in [0, 2m).
    function automatic logic [W:0] mont_ref(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                            input logic [W-1:0] im);
        longint unsigned mv, prod, inv, mask, q, r;
        mv   = 64'(im);
        prod = 64'(ia) * 64'(ib);
        mask = (64'd1 << W) - 64'd1;
        inv  = 64'd1;
        for (int k = 0; k < 6; k++) inv = inv * (64'd2 - mv * inv);
        q = (64'd0 - prod * inv) & mask;
        r = (prod + q * mv) >> W;
`ifdef MMM_FINAL_SUB_EN
        if (r >= mv) r = r - mv;
`endif
        return r[W:0];
    endfunction

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Clock-enable driver
    initial forever begin
        @(posedge clk);
        #1;
        en = en_toggle ? ~en : 1'b1;
    end

    // Issue tracker: models acceptance and occupancy, pushes expected results
    initial forever begin
        @(negedge clk);
        if (checking) begin
            chk_bit("busy", busy, busy_left > 0);
            chk_bit("done", done, busy_left == 1);
        end
        if (rst) begin
            busy_left = 0;
            exp_q.delete();
        end else if (en) begin
            if (busy_left == 0) begin
                if (start) begin
                    exp_q.push_back(mont_ref(a, b, m));
                    busy_left = LAT;
                    cap_count++;
                    $display("issue a=%0d b=%0d m=%0d", a, b, m);
                end
            end else begin
                busy_left--;
            end
        end
    end

    // Monitor: one comparison per done pulse
    initial begin
        logic prev_done;
        logic [W:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (checking && done === 1'b1 && prev_done !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got p=%0d expected no done at %0t", p, $time);
                end else begin
                    e = exp_q.pop_front();
                    $display("result p=%0d expected %0d", p, e);
                    chk("p", p, e);
                end
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy_left != 0 || exp_q.size() != 0) && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (k >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy_left=%0d expected 0", busy_left);
        end
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] im);
        int c0, k;
        wait_idle();
        @(posedge clk);
        #2;
        c0 = cap_count;
        a = ia; b = ib; m = im; start = 1'b1;
        k = 0;
        while (cap_count == c0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #2;
        start = 1'b0;
        if (k >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL capture_timeout: got no capture expected one");
        end
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk("rst_p", p, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rm, ra, rb;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        checking = 1;
        check_reset_state();

        issue(8'd5, 8'd7, 8'd13);
        issue(8'd250, 8'd250, 8'd251);
        issue(8'd0, 8'd200, 8'd201);
        issue(8'd0, 8'd0, 8'd201);
        wait_idle();

        en_toggle = 1;
        issue(8'd5, 8'd7, 8'd13);
        wait_idle();
        en_toggle = 0;

        // start held while busy; operands change mid-operation
        @(posedge clk);
        #2;
        a = 8'd5; b = 8'd7; m = 8'd13; start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #2;
            if (c == 2) begin
                a = 8'd3; b = 8'd9; m = 8'd11;
            end
        end
        start = 1'b0;
        wait_idle();

        // reset in the middle of an operation
        @(posedge clk);
        #2;
        a = 8'd100; b = 8'd50; m = 8'd211; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check_reset_state();
        issue(8'd100, 8'd50, 8'd211);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            rm = W'($urandom_range(3, (1 << W) - 1)) | W'(1);
            ra = W'($urandom_range(0, int'(rm) - 1));
            rb = W'($urandom_range(0, int'(rm) - 1));
            en_toggle = ($urandom_range(0, 3) == 0);
            issue(ra, rb, rm);
        end
        wait_idle();
        en_toggle = 0;

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_done: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mmm_serial_core.md
# mmm_serial_core

Bit-serial Montgomery modular multiplier: the arithmetic datapath stage driven by the modular-exponentiation control unit. It computes P = A·B·2^-W mod M one multiplier bit per enabled clock. Each start/done transaction is one squaring or multiplication step of the RSA exponentiation. Operands come from the exponentiation datapath's operand muxes, and P returns to its result/accumulator registers.

## Interface
Parameters:
- WIDTH, 8, operand width W in bits (W ≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  clock enable; when low, all state holds.
- start  input  1  request a multiplication; sampled only in IDLE with en=1.
- a  input  W  multiplier operand, scanned LSB first.
- b  input  W  multiplicand operand.
- m  input  W  modulus; must be odd, with a < m and b < m.
- busy  output  1  high in every state except IDLE.
- done  output  1  high for exactly one enabled cycle when p is valid.
- p  output  W+1  result; holds its value until the next done.

## Operation
- Operand capture:
  - An enabled start in IDLE latches a, b and m into internal registers.
  - It clears accumulator R (W+2 bits) and bit counter i (ceil(log2 W)+1 bits).
  - It moves the FSM to ITER.
- FSM states: IDLE, ITER, CORR, DONE.
  - IDLE → ITER on start.
  - ITER loops for W enabled cycles, then goes to CORR.
  - CORR → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
- ITER step, once per enabled cycle:
  - T = R + (a_reg[i] ? b_reg : 0).
  - If T is odd, T = T + m_reg.
  - R = T >> 1, and i increments.
  - All sums are evaluated at W+2 bits. The invariant R < 2·m holds, so no overflow occurs.
- CORR: if R ≥ m_reg, p = R − m_reg; otherwise p = R. p[W] is therefore always 0.
- DONE: done=1 for this one cycle. busy stays high.
- start while busy is ignored; captured operands are never overwritten mid-operation.
- Changes on a, b or m after capture have no effect on the running operation.
- If m is even or an operand is ≥ m, the result is unspecified. The FSM must still return to IDLE within the normal latency.
- Reset values: state=IDLE, busy=0, done=0, p=0, R=0, i=0, and operand registers 0.
- rst asserted mid-operation aborts the operation at the next edge. No done is produced. p returns to 0.

## Timing
- Call the enabled edge that samples start "edge 0".
  - ITER iterations occur on edges 1..W.
  - CORR occurs on edge W+1, and p is written there.
  - done is high in the cycle after edge W+1 (DONE state).
  - busy falls at edge W+2.
- Latency is W+2 enabled edges from start to done. For W=8, done rises 10 enabled cycles after start.
- A new start is accepted at earliest in the IDLE cycle after DONE, so back-to-back throughput is one result per W+3 enabled cycles.
- en=0 freezes the FSM, R, i and p. A pending done stays high until the next enabled edge, which then clears it.
- busy and done are registered outputs; there are no combinational paths from inputs to outputs.

## Configuration
- MMM_FINAL_SUB_EN defined:
  - The CORR state exists and performs the conditional subtraction.
  - Guarantees p < m.
  - Latency is W+2.
- MMM_FINAL_SUB_EN undefined:
  - CORR is removed. ITER moves directly to DONE, and p = R is written on the last ITER edge.
  - p lies in [0, 2m) and uses all W+1 bits.
  - Latency is W+1.
  - This mode is for a downstream that tolerates unreduced Montgomery values.

## Test plan
- Basic multiply, W=8, m=13, a=5, b=7, start pulse → done after 10 enabled cycles (9 without the macro), p=1, busy high throughout.
- Final-subtraction path, m=251, a=250, b=250 → with macro p=201. Without macro p=452 (p[8]=1).
- Zero operand, a=0, b=200, m=201 → p=0. Then start with a=b=0 → p=0. done pulses exactly once per start.
- en gating, m=13, a=5, b=7, with en toggling 0/1 every cycle → p=1. done rises after 10 enabled edges and stays high across en=0 cycles until the next enabled edge.
- Busy rejection, start held high for 15 cycles with operands changed at cycle 3 → exactly one done, whose result comes from the first-captured operands. A second operation begins only after busy falls.
- Reset mid-operation, rst asserted at enabled cycle 4 of an operation → next cycle busy=0, done=0, p=0, state IDLE. A following start computes the correct result.
